// File: rtl/prn_cdr_pkg.sv
// rtl/prn_cdr_pkg.sv - shared PRBS7 constants and shift-direction encoding for the PRN CDR
//
// Purpose:
//   Common definitions used by the PRN early/late detector, the transmit PRN
//   source and the tapped delay-line controller.
//   - PRBS7 polynomial x^7 + x^6 + 1, expressed as state-bit tap indices.
//   - shift_dir_e: tap-move command encoding shared with the delay-line controller.
//   - prbs7_step: one Fibonacci step of the PRBS7 register.

package prn_cdr_pkg;

  localparam int PRBS7_LEN = 7;

  // State bit 6 carries the x^7 term and is the output bit. State bit 5
  // carries the x^6 term.
  localparam int PRBS7_TAP_HI = 6;
  localparam int PRBS7_TAP_LO = 5;

  // HOLD: leave the tap alone. DEC: tap index -1 (less delay). INC: tap index +1.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    DEC  = 2'd1,
    INC  = 2'd2
  } shift_dir_e;

  // The register shifts toward the MSB. The feedback bit enters at bit 0, so
  // the bit leaving bit 6 is the oldest bit of the sequence.
  function automatic logic [PRBS7_LEN-1:0] prbs7_step(input logic [PRBS7_LEN-1:0] s);
    return {s[PRBS7_LEN-2:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/prn_lfsr.sv
// rtl/prn_lfsr.sv - enable-gated Fibonacci PRBS7 generator with 1-bit output
//
// Purpose:
//   Local PRBS7 reference. It advances one step on every enabled cycle and
//   holds otherwise. It loads SEED on reset. SEED must be non-zero, otherwise
//   the register stays at all zeros.
//   The same module is used by the transmit PRN source.
//
// Ports:
//   clk  in   1  clock, posedge
//   rst  in   1  synchronous active-high reset, loads SEED
//   en   in   1  step enable
//   prn  out  1  current sequence bit (state MSB)

module prn_lfsr
  import prn_cdr_pkg::*;
#(
  parameter logic [PRBS7_LEN-1:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic prn
);

  logic [PRBS7_LEN-1:0] lfsr_q;
  logic [PRBS7_LEN-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = prbs7_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign prn = lfsr_q[PRBS7_LEN-1];

endmodule

// File: rtl/prn_early_late_detector.sv
// rtl/prn_early_late_detector.sv - PRBS7 early/late phase detector driving delay-line tap moves
//
// Purpose:
//   Correlates the recovered bit stream with three phases of a local PRBS7
//   reference: early e = p[n], prompt m = p[n-1] and late l = p[n-2].
//   Matches are counted over WINDOW enabled samples. At the end of each window
//   the detector issues at most one single-cycle tap-move pulse. It also
//   updates the lock flag and the prompt correlation count.
//
// Ports:
//   clk          in   1      clock, posedge
//   rst          in   1      synchronous active-high reset, has priority over en
//   en           in   1      sample enable. When low, the LFSR, counters and window hold.
//   rx_data      in   1      recovered bit fed back from the delay-line output
//   shift_right  out  1      one-cycle pulse, tap index -1 (rx lags the reference)
//   shift_left   out  1      one-cycle pulse, tap index +1 (rx leads the reference)
//   locked       out  1      prompt_cnt >= LOCK_MIN in the last completed window
//   corr_prompt  out  CNT_W  prompt match count of the last completed window

module prn_early_late_detector
  import prn_cdr_pkg::*;
#(
  parameter int                   WINDOW   = 64,
  parameter int                   THRESH   = 8,
  parameter int                   LOCK_MIN = 56,
  parameter logic [PRBS7_LEN-1:0] SEED     = 7'h7F,
  localparam int                  CNT_W    = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx_data,
  output logic             shift_right,
  output logic             shift_left,
  output logic             locked,
  output logic [CNT_W-1:0] corr_prompt
);

  // The difference is signed and one bit wider than the counters, so it holds
  // every value from -WINDOW to +WINDOW.
  localparam logic signed [CNT_W:0] THRESH_POS = (CNT_W + 1)'(THRESH);
  localparam logic signed [CNT_W:0] THRESH_NEG = -THRESH_POS;
  localparam logic [CNT_W-1:0]      LAST_IDX   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]      LOCK_LVL   = CNT_W'(LOCK_MIN);

  logic prn;

  prn_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .prn (prn)
  );

  // hist_q[0] is the prompt reference p[n-1]. hist_q[1] is the late reference p[n-2].
  logic [1:0]       hist_q,   hist_d;
  logic [CNT_W-1:0] early_q,  early_d;
  logic [CNT_W-1:0] prompt_q, prompt_d;
  logic [CNT_W-1:0] late_q,   late_d;
  logic [CNT_W-1:0] win_q,    win_d;
  shift_dir_e       shift_q,  shift_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] corr_q,   corr_d;

  logic             ref_early;
  logic             ref_prompt;
  logic             ref_late;
  logic [CNT_W-1:0] early_sum;
  logic [CNT_W-1:0] prompt_sum;
  logic [CNT_W-1:0] late_sum;
  logic signed [CNT_W:0] diff;

  assign ref_early  = prn;
  assign ref_prompt = hist_q[0];
  assign ref_late   = hist_q[1];

  // These are the counts that include the current sample. The dump decision
  // uses them, so the last sample of a window is counted.
  assign early_sum  = early_q  + {{(CNT_W-1){1'b0}}, rx_data == ref_early};
  assign prompt_sum = prompt_q + {{(CNT_W-1){1'b0}}, rx_data == ref_prompt};
  assign late_sum   = late_q   + {{(CNT_W-1){1'b0}}, rx_data == ref_late};
  assign diff       = $signed({1'b0, late_sum}) - $signed({1'b0, early_sum});

  always_comb begin
    hist_d   = hist_q;
    early_d  = early_q;
    prompt_d = prompt_q;
    late_d   = late_q;
    win_d    = win_q;
    shift_d  = HOLD;       // a pulse lasts one cycle, whatever en does next
    locked_d = locked_q;
    corr_d   = corr_q;

    if (en) begin
      hist_d = {hist_q[0], prn};
      if (win_q == LAST_IDX) begin
        // Dump. Decide the tap move, publish the lock status, then start a
        // fresh window on the next sample.
        if (diff > THRESH_POS) begin
          shift_d = DEC;
        end else if (diff < THRESH_NEG) begin
          shift_d = INC;
        end
        locked_d = (prompt_sum >= LOCK_LVL);
        corr_d   = prompt_sum;
        early_d  = '0;
        prompt_d = '0;
        late_d   = '0;
        win_d    = '0;
      end else begin
        early_d  = early_sum;
        prompt_d = prompt_sum;
        late_d   = late_sum;
        win_d    = win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '0;
      early_q  <= '0;
      prompt_q <= '0;
      late_q   <= '0;
      win_q    <= '0;
      shift_q  <= HOLD;
      locked_q <= 1'b0;
      corr_q   <= '0;
    end else begin
      hist_q   <= hist_d;
      early_q  <= early_d;
      prompt_q <= prompt_d;
      late_q   <= late_d;
      win_q    <= win_d;
      shift_q  <= shift_d;
      locked_q <= locked_d;
      corr_q   <= corr_d;
    end
  end

  // A single encoded register drives both pulses, so they can never be high together.
  assign shift_right = (shift_q == DEC);
  assign shift_left  = (shift_q == INC);
  assign locked      = locked_q;
  assign corr_prompt = corr_q;

endmodule
